core_sequencer: RTL

//  Multi-cycle control FSM for the RV32I core datapath (pc, instr memory, decoder, regfile, alu).

---
 rtl/core_seq_pkg.sv | 22 ++
 rtl/core_sequencer_imem_watchdog.sv | 25 ++
 rtl/core_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and instruction constants for the RV32I multi-cycle sequencer.
package core_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT,
        FAULT
    } state_t;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    function automatic logic is_halt(input logic [31:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/core_sequencer_imem_watchdog.sv
// Fetch wait counter: counts FETCH cycles without ack, flags expiry at FETCH_TIMEOUT.
module imem_watchdog #(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(FETCH_TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath: fetch handshake, IR, decode/execute pacing.
// Optional performance counters are built when CORE_SEQ_PERF_EN is defined.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int FETCH_TIMEOUT = 15
`ifdef CORE_SEQ_PERF_EN
    ,
    parameter int CNT_W         = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] ir,
    input  logic            stall,
    input  logic            dec_w_enable,
    output logic            rf_we,
    output logic            pc_en,
    output logic            halted,
    output logic            fault
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t state;
    logic   wd_expired;
    logic   wb_fire;

    imem_watchdog #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != FETCH),
        .enable ((state == FETCH) && !imem_ack),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            ir       <= XLEN'(INSTR_NOP);
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    // An ack in the cycle the watchdog expires still completes the fetch.
                    if (imem_ack) begin
                        ir       <= instr_in;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end else if (wd_expired) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        if (is_halt(ir[31:0])) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else if (ir[1:0] != 2'b11) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            state <= EXECUTE;
                        end
                    end
                end
                EXECUTE: begin
                    if (!stall) state <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (!stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HALT, FAULT: state <= state;
                default:     state <= IDLE;
            endcase
        end
    end

    // Strobes decode the registered state but must drop in the very cycle stall or reset is high,
    // so they are gated combinationally rather than pre-registered.
    assign wb_fire = (state == WRITEBACK) && !stall && !reset;
    assign pc_en   = wb_fire;
    assign rf_we   = wb_fire && dec_w_enable;

`ifdef CORE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state inside {FETCH, DECODE, EXECUTE, WRITEBACK}) cycle_cnt <= cycle_cnt + 1'b1;
            if (wb_fire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule
